spi_master_sched: RTL

- Single-master SPI controller that time-shares one SPIbus among NREQ on-chip requesters, round-robin.
- Each granted request is one 8-bit full-duplex transfer to one slave selected by index. Slave select is active high; data is MSB first.
- Timing is sized so the existing synchronizing slave (2-flop sck/mosi sync, rising-edge shift, load on ss rise) receives and transmits correctly.
- Sits between local clients and the SPIbus.Master modport.

---
 rtl/spi_master_sched_if.sv | 12 +
 rtl/spi_master_sched.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/spi_master_sched_if.sv
// rtl/spi_master_sched_if.sv - SPI bus signals shared by the scheduler and its slaves
interface spi_master_sched_if #(
  parameter int NSLV = 4
);
  logic            sck;
  logic            mosi;
  logic            miso;
  logic [NSLV-1:0] ss;

  modport master (output sck, output mosi, output ss, input miso);
  modport slave  (input sck, input mosi, input ss, output miso);
endinterface

// File: rtl/spi_master_sched.sv
// rtl/spi_master_sched.sv - round-robin SPI master: one 8-bit MSB-first transfer per grant
// Timing leaves enough margin for a slave that 2-flop syncs sck/mosi and loads on ss rise.
module spi_master_sched #(
  parameter int NREQ     = 4,
  parameter int NSLV     = 4,
  parameter int CLK_DIV  = 4,
  parameter int SS_SETUP = 6,
  parameter int SS_HOLD  = 4,
  parameter int GAP      = 4,
  localparam int SW      = (NSLV > 1) ? $clog2(NSLV) : 1
) (
  input  logic                 Clk_i,
  input  logic                 Rst_ni,
  spi_master_sched_if.master   Spim,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ*SW-1:0]   dst_i,
  input  logic [8*NREQ-1:0]    tx_data_i,
  output logic [NREQ-1:0]      gnt_o,
  output logic [NREQ-1:0]      done_o,
  output logic                 err_o,
  output logic [7:0]           rx_data_o,
  output logic                 busy_o
);
  localparam int PW   = $clog2(NREQ);
  localparam int CM1  = (SS_SETUP > CLK_DIV) ? SS_SETUP : CLK_DIV;
  localparam int CM2  = (SS_HOLD > GAP) ? SS_HOLD : GAP;
  localparam int CMAX = (CM1 > CM2) ? CM1 : CM2;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_XFER, S_HOLD, S_DONE, S_ERR, S_GAP
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt;
  logic [3:0]      half_idx;
  logic [PW-1:0]   ptr, win, win_q;
  logic            found;
  logic [NREQ-1:0] gnt_q;
  logic [SW-1:0]   dst_q;
  logic            dst_ok;
  logic [7:0]      tx_sh, rx_sh;
  logic [NSLV-1:0] ss_sel;
  logic            div_end;
  int              j;

  assign div_end = (cnt == CW'(CLK_DIV - 1));
  assign ss_sel  = dst_ok ? (NSLV'(1) << dst_q) : '0;

  // Round-robin search starting at the pointer, wrapping past NREQ-1.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!found && req_i[j]) begin
        found = 1'b1;
        win   = PW'(j);
      end
    end
  end

  always_ff @(posedge Clk_i or negedge Rst_ni) begin
    if (!Rst_ni) state <= S_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (found) state_n = S_SETUP;
      S_SETUP: if (!dst_ok) state_n = S_ERR;
               else if (cnt == CW'(SS_SETUP - 1)) state_n = S_XFER;
      S_XFER:  if (div_end && half_idx == 4'd15) state_n = S_HOLD;
      S_HOLD:  if (cnt == CW'(SS_HOLD - 1)) state_n = S_DONE;
      S_DONE:  state_n = S_GAP;
      S_ERR:   state_n = S_GAP;
      S_GAP:   if (cnt == CW'(GAP - 1)) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    Spim.sck  = 1'b0;
    Spim.mosi = 1'b0;
    Spim.ss   = '0;
    done_o    = '0;
    err_o     = 1'b0;
    gnt_o     = gnt_q;
    busy_o    = (state != S_IDLE);
    case (state)
      S_SETUP: begin
        Spim.ss   = ss_sel;
        Spim.mosi = dst_ok & tx_sh[7];
      end
      S_XFER: begin
        Spim.ss   = ss_sel;
        Spim.sck  = half_idx[0];
        Spim.mosi = tx_sh[7];
      end
      S_HOLD:  Spim.ss = ss_sel;
      S_DONE:  done_o = gnt_q;
      S_ERR: begin
        done_o = gnt_q;
        err_o  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk_i or negedge Rst_ni) begin
    if (!Rst_ni) begin
      cnt       <= '0;
      half_idx  <= '0;
      ptr       <= '0;
      win_q     <= '0;
      gnt_q     <= '0;
      dst_q     <= '0;
      dst_ok    <= 1'b0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      rx_data_o <= '0;
    end else begin
      // cnt counts cycles within a state; in XFER it is the half-period divider.
      if (state_n != state) begin
        cnt      <= '0;
        half_idx <= '0;
      end else if (state == S_XFER && div_end) begin
        cnt      <= '0;
        half_idx <= half_idx + 4'd1;
      end else if (state != S_IDLE) begin
        cnt <= cnt + 1'b1;
      end

      if (state == S_IDLE && found) begin
        gnt_q  <= NREQ'(1) << win;
        win_q  <= win;
        dst_q  <= dst_i[int'(win)*SW +: SW];
        dst_ok <= int'(dst_i[int'(win)*SW +: SW]) < NSLV;
        tx_sh  <= tx_data_i[int'(win)*8 +: 8];
      end

      // Odd half-periods are sck high: their end is a falling edge, even ends precede a rise.
      if (state == S_XFER && div_end) begin
        if (half_idx[0] && half_idx != 4'd15) tx_sh <= {tx_sh[6:0], 1'b0};
        if (!half_idx[0]) rx_sh <= {rx_sh[6:0], Spim.miso};
      end

      if (state == S_HOLD && state_n == S_DONE) rx_data_o <= rx_sh;

      if (state == S_DONE || state == S_ERR) begin
        gnt_q <= '0;
        ptr   <= (int'(win_q) == NREQ - 1) ? '0 : win_q + 1'b1;
      end
    end
  end
endmodule
